// File: rtl/seg_scan_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_t;

    // {g,f,e,d,c,b,a}, 1 = segment lit
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        for (int unsigned k = 0; k < 10; k++) begin
            if (bcd_i == 4'(k)) seg_o = SEG_LUT[k];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with dead-time blanking, frame-coherent
// value commit by load/ack, and optional leading-zero suppression.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 2,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned SCAN_HZ      = 1_000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    output logic                  load_ack,
    input  logic                  lz_blank_en,
    output logic [6:0]            seg_out,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  frame_start
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIV) begin : g_bad_blank
        $error("seg_scan_ctrl: BLANK_CYCLES must be in 1..DIV-1");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_ctrl: N_DIGITS must be in 1..8");
    end

    scan_state_t           state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_q, pend_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic                  full_q, full_d;

    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   dig_q, dig_d;
    logic                  ack_q, fs_q;

    logic                  slot_end, boundary;
    logic [3:0]            cur_digit;
    logic [6:0]            dec_seg;
    logic [N_DIGITS-1:0]   lz_mask;
    logic                  zero_above, lz_hit;

    // BLANK with tick 0 only occurs straight out of reset: that is the 1-tick lead-in.
    always_comb begin
        slot_end = (state_q == BLANK) && ((tick_q == TICK_LAST) || (tick_q == '0));
        boundary = slot_end && (idx_q == IDX_LAST);

        tick_d  = slot_end ? '0 : tick_q + 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        if (slot_end) begin
            state_d = SHOW;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else if (state_q == SHOW && tick_q == SHOW_LAST) begin
            state_d = BLANK;
        end

        // Commit uses the older pending; a load in the same cycle refills it.
        shadow_d = shadow_q;
        pend_d   = pend_q;
        full_d   = full_q;
        if (boundary && full_q) begin
            shadow_d = pend_q;
            full_d   = 1'b0;
        end
        if (load) begin
            pend_d = value_in;
            full_d = 1'b1;
        end
    end

    always_comb begin
        cur_digit  = '0;
        lz_hit     = 1'b0;
        dig_d      = '0;
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int unsigned j = 0; j < N_DIGITS - 1; j++) begin
            zero_above = zero_above && (shadow_d[4*(N_DIGITS-1-j) +: 4] == 4'h0);
            lz_mask[N_DIGITS-1-j] = lz_blank_en && zero_above;
        end
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IW'(k)) begin
                cur_digit = shadow_d[4*k +: 4];
                lz_hit    = lz_mask[k];
            end
            dig_d[k] = (state_d == SHOW) && (idx_d == IW'(k));
        end
        seg_d = (state_d == SHOW && !lz_hit) ? dec_seg : SEG_OFF;
    end

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= BLANK;
            tick_q   <= '0;
            idx_q    <= IDX_LAST;
            pend_q   <= '0;
            shadow_q <= '0;
            full_q   <= 1'b0;
            seg_q    <= SEG_OFF;
            dig_q    <= '0;
            ack_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
            ack_q    <= boundary && full_q;
            fs_q     <= boundary;
        end
    end

    assign seg_out     = seg_q;
    assign dig_sel     = dig_q;
    assign load_ack    = ack_q;
    assign frame_start = fs_q;

endmodule
